// File: rtl/microcode_sequencer.sv
// Microprogram sequencer for the ARC datapath: writable control store, CSAR and a
// registered MIR, with next-address selection from MIR cond/jump, flags, IR13 and opcode.
module microcode_sequencer #(
    parameter int OPCODE_WIDTH = 8,
    parameter int ADDR_WIDTH   = 11,
    parameter int MIR_WIDTH    = 41
) (
    input  logic                    MICROSEQ_CLOCK_50,
    input  logic                    MICROSEQ_ResetInLow_In,
    input  logic                    MICROSEQ_Start_In,
    input  logic                    MICROSEQ_Halt_In,
    input  logic                    MICROSEQ_Stall_In,
    input  logic [3:0]              MICROSEQ_Flags_InBus,
    input  logic                    MICROSEQ_IR13_In,
    input  logic [OPCODE_WIDTH-1:0] MICROSEQ_Opcode_InBus,
    input  logic                    MICROSEQ_LoadValid_In,
    input  logic [ADDR_WIDTH-1:0]   MICROSEQ_LoadAddr_InBus,
    input  logic [MIR_WIDTH-1:0]    MICROSEQ_LoadData_InBus,
    output logic                    MICROSEQ_LoadReady_Out,
    output logic [MIR_WIDTH-1:0]    MICROSEQ_MIR_OutBus,
    output logic [ADDR_WIDTH-1:0]   MICROSEQ_CSAddress_OutBus,
    output logic                    MICROSEQ_Running_Out,
    output logic                    MICROSEQ_Wrap_Out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic {HALT = 1'b0, RUN = 1'b1} seqState_t;

    seqState_t state, stateNext;

    logic [MIR_WIDTH-1:0]  controlStore [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] csar, csarNext, jumpAddr, seqAddr, decodeAddr, branchAddr, fetchAddr;
    logic [MIR_WIDTH-1:0]  mir, mirNext, fetchData;
    logic [2:0]            cond;
    logic                  takeJump, incSel, wrapNext, wrapQ, storeWrite;

    assign cond       = mir[ADDR_WIDTH+2:ADDR_WIDTH];
    assign jumpAddr   = mir[ADDR_WIDTH-1:0];
    assign seqAddr    = csar + ADDR_WIDTH'(1);
    assign decodeAddr = {1'b1, MICROSEQ_Opcode_InBus, 2'b00};
    assign storeWrite = (state == HALT) && MICROSEQ_LoadValid_In;

    always_comb begin
        takeJump = 1'b0;
        unique case (cond)
            3'b001:  takeJump = MICROSEQ_Flags_InBus[3];
            3'b010:  takeJump = MICROSEQ_Flags_InBus[2];
            3'b011:  takeJump = MICROSEQ_Flags_InBus[1];
            3'b100:  takeJump = MICROSEQ_Flags_InBus[0];
            3'b101:  takeJump = MICROSEQ_IR13_In;
            3'b110:  takeJump = 1'b1;
            default: takeJump = 1'b0;
        endcase
    end

    assign incSel     = (cond != 3'b111) && !takeJump;
    assign branchAddr = (cond == 3'b111) ? decodeAddr : (takeJump ? jumpAddr : seqAddr);

    // Write-first bypass: a Start coinciding with a load to address 0 sees the new word.
    assign fetchAddr = (state == HALT) ? '0 : branchAddr;
    assign fetchData = (storeWrite && (MICROSEQ_LoadAddr_InBus == fetchAddr))
                       ? MICROSEQ_LoadData_InBus : controlStore[fetchAddr];

    always_ff @(posedge MICROSEQ_CLOCK_50) begin
        if (storeWrite)
            controlStore[MICROSEQ_LoadAddr_InBus] <= MICROSEQ_LoadData_InBus;
    end

    always_comb begin
        stateNext = state;
        csarNext  = csar;
        mirNext   = mir;
        wrapNext  = 1'b0;
        unique case (state)
            HALT: begin
                if (MICROSEQ_Start_In && !MICROSEQ_Halt_In) begin
                    stateNext = RUN;
                    csarNext  = '0;
                    mirNext   = fetchData;
                end
            end
            RUN: begin
                if (MICROSEQ_Halt_In) begin
                    stateNext = HALT;
                    csarNext  = '0;
                    mirNext   = '0;
                end else if (!MICROSEQ_Stall_In) begin
                    csarNext = branchAddr;
                    mirNext  = fetchData;
                    wrapNext = incSel && (csar == ALL_ONES);
                end
            end
            default: stateNext = HALT;
        endcase
    end

    always_ff @(posedge MICROSEQ_CLOCK_50 or negedge MICROSEQ_ResetInLow_In) begin
        if (!MICROSEQ_ResetInLow_In) begin
            state <= HALT;
            csar  <= '0;
            mir   <= '0;
            wrapQ <= 1'b0;
        end else begin
            state <= stateNext;
            csar  <= csarNext;
            mir   <= mirNext;
            wrapQ <= wrapNext;
        end
    end

    assign MICROSEQ_LoadReady_Out    = (state == HALT);
    assign MICROSEQ_Running_Out      = (state == RUN);
    assign MICROSEQ_MIR_OutBus       = mir;
    assign MICROSEQ_CSAddress_OutBus = csar;
    assign MICROSEQ_Wrap_Out         = wrapQ;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed test-plan steps followed by random cycles,
// all checked against an array-based reference model of the sequencing rules.
module tb_microcode_sequencer;

    localparam int OW = 8;
    localparam int AW = 11;
    localparam int MW = 41;

    logic          clk = 1'b0;
    logic          rstN;
    logic          start, halt, stall, ir13, loadValid;
    logic [3:0]    flags;
    logic [OW-1:0] opcode;
    logic [AW-1:0] loadAddr;
    logic [MW-1:0] loadData;
    logic          loadReady, running, wrap;
    logic [MW-1:0] mirOut;
    logic [AW-1:0] csaOut;

    microcode_sequencer #(.OPCODE_WIDTH(OW), .ADDR_WIDTH(AW), .MIR_WIDTH(MW)) dut (
        .MICROSEQ_CLOCK_50         (clk),
        .MICROSEQ_ResetInLow_In    (rstN),
        .MICROSEQ_Start_In         (start),
        .MICROSEQ_Halt_In          (halt),
        .MICROSEQ_Stall_In         (stall),
        .MICROSEQ_Flags_InBus      (flags),
        .MICROSEQ_IR13_In          (ir13),
        .MICROSEQ_Opcode_InBus     (opcode),
        .MICROSEQ_LoadValid_In     (loadValid),
        .MICROSEQ_LoadAddr_InBus   (loadAddr),
        .MICROSEQ_LoadData_InBus   (loadData),
        .MICROSEQ_LoadReady_Out    (loadReady),
        .MICROSEQ_MIR_OutBus       (mirOut),
        .MICROSEQ_CSAddress_OutBus (csaOut),
        .MICROSEQ_Running_Out      (running),
        .MICROSEQ_Wrap_Out         (wrap)
    );

    always #5 clk = ~clk;

    int nAssert = 0;
    int nFail   = 0;

    // Reference model
    logic [MW-1:0] mMem [2048];
    int            mCsar;
    logic [MW-1:0] mMir;
    bit            mRun, mWrap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        chk("mir", 64'(mirOut), 64'(mMir));
        chk("csaddr", 64'(csaOut), 64'(mCsar));
        chk("running", 64'(running), 64'(mRun));
        chk("loadready", 64'(loadReady), 64'(!mRun));
        chk("wrap", 64'(wrap), 64'(mWrap));
    endtask

    // One rising edge worth of the sequencing rules, using the inputs currently driven.
    task automatic modelStep();
        int c, nxt;
        bit take;
        mWrap = 1'b0;
        if (!mRun) begin
            if (loadValid) mMem[loadAddr] = loadData;
            if (start && !halt) begin
                mRun = 1'b1; mCsar = 0; mMir = mMem[0];
            end
        end else if (halt) begin
            mRun = 1'b0; mCsar = 0; mMir = '0;
        end else if (!stall) begin
            c = int'(mMir[13:11]);
            take = (c >= 1 && c <= 4) ? flags[4-c] : (c == 5) ? ir13 : (c == 6);
            if (c == 7)       nxt = 1024 + int'(opcode) * 4;
            else if (take)    nxt = int'(mMir[10:0]);
            else begin
                nxt = (mCsar + 1) % 2048;
                mWrap = (mCsar == 2047);
            end
            mCsar = nxt; mMir = mMem[nxt];
        end
    endtask

    task automatic cycle();
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    function automatic logic [MW-1:0] mkMi(input int cond, input int jump);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        r[13:11] = 3'(cond);
        r[10:0]  = 11'(jump);
        return r[MW-1:0];
    endfunction

    task automatic load(input int addr, input logic [MW-1:0] data);
        loadValid = 1'b1; loadAddr = AW'(addr); loadData = data;
        cycle();
        loadValid = 1'b0;
    endtask

    task automatic doStart();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic doHalt();
        halt = 1'b1; cycle(); halt = 1'b0;
    endtask

    logic [MW-1:0] wA, wB, wC, decodeMi, saved3;
    logic [63:0]   r64;

    initial begin
        rstN = 1'b0; start = 0; halt = 0; stall = 0; ir13 = 0; loadValid = 0;
        flags = '0; opcode = '0; loadAddr = '0; loadData = '0;
        mCsar = 0; mMir = '0; mRun = 0; mWrap = 0;
        #12;
        checkAll();
        rstN = 1'b1;

        // Fill the whole store so every fetch the random phase makes is defined.
        for (int a = 0; a < 2048; a++) begin
            r64 = {$urandom(), $urandom()};
            load(a, r64[MW-1:0]);
        end

        // Reset/load/start
        wA = mkMi(0, 123); wB = mkMi(0, 456);
        load(0, wA); load(1, wB);
        doStart();
        chk("start_mir", 64'(mirOut), 64'(wA));
        chk("start_csa", 64'(csaOut), 64'd0);
        cycle();
        chk("step_mir", 64'(mirOut), 64'(wB));
        chk("step_csa", 64'(csaOut), 64'd1);
        doHalt();
        chk("halt_running", 64'(running), 64'd0);

        // Conditional branches on n, z, v, c and IR13, taken and not taken
        for (int c = 1; c <= 5; c++) begin
            for (int t = 0; t < 2; t++) begin
                load(1, mkMi(6, 5));
                load(5, mkMi(c, 'h640));
                doStart(); cycle(); cycle();
                chk("at5_csa", 64'(csaOut), 64'd5);
                if (c <= 4) begin
                    flags = t[0] ? 4'(1 << (4 - c)) : ~4'(1 << (4 - c));
                    ir13  = 1'($urandom());
                end else begin
                    flags = 4'($urandom());
                    ir13  = t[0];
                end
                cycle();
                chk($sformatf("branch_c%0d_t%0d", c, t), 64'(csaOut), t[0] ? 64'h640 : 64'd6);
                doHalt();
            end
        end

        // Decode: addcc opcode lands on 1600
        decodeMi = mkMi(0, 77);
        load(5, mkMi(0, 0)); load(6, mkMi(7, 99)); load(1600, decodeMi);
        doStart(); cycle(); cycle(); cycle();
        opcode = 8'b10010000;
        cycle();
        chk("decode_csa", 64'(csaOut), 64'd1600);
        chk("decode_mir", 64'(mirOut), 64'(decodeMi));

        // Stall for three cycles, then resume
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_csa", 64'(csaOut), 64'd1600);
            chk("stall_mir", 64'(mirOut), 64'(decodeMi));
        end
        stall = 1'b0;
        cycle();
        chk("resume_csa", 64'(csaOut), 64'd1601);

        // Halt wins over Stall
        stall = 1'b1; halt = 1'b1; cycle(); stall = 1'b0; halt = 1'b0;
        chk("stallhalt_running", 64'(running), 64'd0);
        chk("stallhalt_mir", 64'(mirOut), 64'd0);

        // Wrap at 2047, with a load attempt while running
        saved3 = mMem[3];
        load(1, mkMi(6, 2047)); load(2047, mkMi(0, 5));
        doStart(); cycle(); cycle();
        chk("pre_wrap_csa", 64'(csaOut), 64'd2047);
        chk("pre_wrap", 64'(wrap), 64'd0);
        loadValid = 1'b1; loadAddr = AW'(3); loadData = ~saved3;
        cycle();
        loadValid = 1'b0;
        chk("wrap_csa", 64'(csaOut), 64'd0);
        chk("wrap_pulse", 64'(wrap), 64'd1);
        cycle();
        chk("wrap_clear", 64'(wrap), 64'd0);
        doHalt();

        // Store must not have taken the RUN-time write
        load(1, mkMi(6, 3));
        doStart(); cycle(); cycle();
        chk("blocked_csa", 64'(csaOut), 64'd3);
        chk("blocked_mir", 64'(mirOut), 64'(saved3));

        // Asynchronous reset mid-RUN
        #2 rstN = 1'b0;
        #1;
        mRun = 0; mCsar = 0; mMir = '0; mWrap = 0;
        checkAll();
        #2 rstN = 1'b1;
        doStart();
        chk("post_reset_mir", 64'(mirOut), 64'(wA));
        doHalt();

        // Write-first on Start with a load to address 0
        wC = mkMi(0, 321);
        loadValid = 1'b1; loadAddr = '0; loadData = wC; start = 1'b1;
        cycle();
        loadValid = 1'b0; start = 1'b0;
        chk("writefirst_mir", 64'(mirOut), 64'(wC));
        doHalt();

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(3) == 0);
            halt      = ($urandom_range(31) == 0);
            stall     = ($urandom_range(4) == 0);
            flags     = 4'($urandom());
            ir13      = 1'($urandom());
            opcode    = 8'($urandom());
            loadValid = 1'($urandom());
            loadAddr  = AW'($urandom());
            r64       = {$urandom(), $urandom()};
            loadData  = r64[MW-1:0];
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
